// File: rtl/tau_dot_sequencer.sv
// Feeds (a,b) pairs to the serial tau MAC and reports one dot product per vector.
// The MAC never clears, so each result is the MAC value at vector end minus a start snapshot.
module tau_dot_sequencer #(
  parameter int BITWIDTH  = 8,
  parameter int OUT_WIDTH = 2 * BITWIDTH,
  parameter int MAX_LEN   = 16,
  parameter int CNT_W     = $clog2(MAX_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BITWIDTH-1:0]  in_a,
  input  logic [BITWIDTH-1:0]  in_b,
  input  logic                 in_last,
  output logic [BITWIDTH-1:0]  mac_a,
  output logic [BITWIDTH-1:0]  mac_b,
  output logic                 mac_start,
  input  logic [OUT_WIDTH-1:0] mac_in,
  input  logic                 mac_valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_sum,
  output logic [CNT_W-1:0]     out_count,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_OUTPUT
  } state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(MAX_LEN);

  state_t               r_state;
  state_t               w_next;
  logic [BITWIDTH-1:0]  r_a;
  logic [BITWIDTH-1:0]  r_b;
  logic                 r_last;
  logic [OUT_WIDTH-1:0] r_base;
  logic [CNT_W-1:0]     r_cnt;
  logic [OUT_WIDTH-1:0] r_sum;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic                 w_close;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_close   = r_last || (w_cnt_inc == LP_MAX);

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    mac_start = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        mac_start = 1'b1;
        w_next    = S_SETTLE;
      end
      // MAC still shows idle the cycle after start
      S_SETTLE: w_next = S_WAIT;
      S_WAIT: begin
        if (mac_valid) w_next = w_close ? S_OUTPUT : S_IDLE;
      end
      S_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_last  <= 1'b0;
      r_base  <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && in_valid) begin
        r_a    <= in_a;
        r_b    <= in_b;
        r_last <= in_last;
        if (r_cnt == '0) r_base <= mac_in;
      end
      if (r_state == S_WAIT && mac_valid) begin
        if (w_close) begin
          r_sum   <= mac_in - r_base;
          r_count <= w_cnt_inc;
          r_cnt   <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign mac_a     = r_a;
  assign mac_b     = r_b;
  assign out_sum   = r_sum;
  assign out_count = r_count;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_tau_dot_sequencer.sv
// Bench for tau_dot_sequencer with a behavioural serial MAC.
// Expected sums/latencies come from plain per-vector arithmetic.
module tb_tau_dot_sequencer;

  localparam int BW   = 8;
  localparam int OW   = 16;
  localparam int ML   = 4;
  localparam int CW   = $clog2(ML + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_a;
  logic [BW-1:0] in_b;
  logic          in_last;
  logic [BW-1:0] mac_a;
  logic [BW-1:0] mac_b;
  logic          mac_start;
  logic [OW-1:0] mac_in;
  logic          mac_valid;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tau_dot_sequencer #(.BITWIDTH(BW), .MAX_LEN(ML)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .mac_a(mac_a), .mac_b(mac_b), .mac_start(mac_start),
    .mac_in(mac_in), .mac_valid(mac_valid),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .busy(busy)
  );

  // Serial MAC: popcount(a) cycles of work, plus one stale-idle cycle after start
  logic [OW-1:0] m_acc;
  logic [4:0]    m_cnt;
  logic          m_js;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_acc <= '0;
      m_cnt <= '0;
      m_js  <= 1'b0;
    end else begin
      m_js <= 1'b0;
      if (mac_start) begin
        m_cnt <= 5'($countones(mac_a)) + 5'd1;
        m_js  <= 1'b1;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 5'd1;
        if (m_cnt == 5'd1) m_acc <= m_acc + OW'(mac_a) * OW'(mac_b);
      end
    end
  end

  assign mac_in    = m_acc;
  assign mac_valid = m_js || (m_cnt == 0);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Sends one pair; returns cycles from accept to in_ready/out_valid rise.
  task automatic drive_pair(input logic [7:0] a, input logic [7:0] b,
                            input logic lst, output int lat,
                            output bit start_ok, output bit hold_ok,
                            output bit tmo);
    int w = 0;
    tmo      = 1'b0;
    start_ok = 1'b1;
    hold_ok  = 1'b1;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (!in_ready) tmo = 1'b1;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = lst;
    step();
    in_valid = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    if (!(mac_start && mac_a == a && mac_b == b)) start_ok = 1'b0;
    lat = 1;
    while (!(in_ready || out_valid) && lat < 60) begin
      if (mac_a !== a || mac_b !== b) hold_ok = 1'b0;
      if (mac_start && lat > 1) start_ok = 1'b0;
      step();
      lat++;
    end
    if (!(in_ready || out_valid)) tmo = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({in_ready, busy, out_valid, mac_start} !== 4'b1000 ||
        mac_a !== 0 || mac_b !== 0 || out_sum !== 0 || out_count !== 0) begin
      fails++;
      $display("FAIL reset: rdy=%b busy=%b ov=%b st=%b a=%h b=%h sum=%0d cnt=%0d want 1 0 0 0 0 0 0 0",
               in_ready, busy, out_valid, mac_start, mac_a, mac_b, out_sum, out_count);
    end
  endtask

  task automatic test_single();
    int lat;
    bit sok, hok, tmo;
    drive_pair(8'h0B, 8'h03, 1'b1, lat, sok, hok, tmo);
    tests++;
    if (lat != 7 || !sok || !hok || tmo || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL single_timing: lat=%0d start=%b hold=%b tmo=%b ov=%b want 7 1 1 0 1",
               lat, sok, hok, tmo, out_valid);
    end
    tests++;
    if (out_sum !== 16'd33 || out_count !== 3'd1) begin
      fails++;
      $display("FAIL single_result: sum=%0d cnt=%0d want 33 1", out_sum, out_count);
    end
    step();
  endtask

  task automatic test_vector();
    int lat;
    bit sok, hok, tmo;
    drive_pair(8'd2, 8'd5, 1'b0, lat, sok, hok, tmo);
    tests++;
    if (lat != 5 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL vec_first: lat=%0d rdy=%b ov=%b want 5 1 0", lat, in_ready, out_valid);
    end
    drive_pair(8'd0, 8'd9, 1'b0, lat, sok, hok, tmo);
    tests++;
    if (lat != 4 || !sok || tmo) begin
      fails++;
      $display("FAIL vec_zero_a: lat=%0d start=%b tmo=%b want 4 1 0", lat, sok, tmo);
    end
    drive_pair(8'd255, 8'd255, 1'b1, lat, sok, hok, tmo);
    tests++;
    if (lat != 12 || out_valid !== 1'b1 || out_sum !== 16'd65035 || out_count !== 3'd3) begin
      fails++;
      $display("FAIL vec_result: lat=%0d ov=%b sum=%0d cnt=%0d want 12 1 65035 3",
               lat, out_valid, out_sum, out_count);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit sok, hok, tmo;
    drive_pair(8'd255, 8'd255, 1'b1, lat, sok, hok, tmo);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd65025 || out_count !== 3'd1) begin
      fails++;
      $display("FAIL b2b_first: ov=%b sum=%0d cnt=%0d want 1 65025 1", out_valid, out_sum, out_count);
    end
    step();
    drive_pair(8'd255, 8'd255, 1'b0, lat, sok, hok, tmo);
    drive_pair(8'd255, 8'd255, 1'b1, lat, sok, hok, tmo);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd64514 || out_count !== 3'd2) begin
      fails++;
      $display("FAIL b2b_wrap: ov=%b sum=%0d cnt=%0d want 1 64514 2", out_valid, out_sum, out_count);
    end
    step();
  endtask

  task automatic test_maxlen();
    int lat;
    bit sok, hok, tmo;
    for (int i = 0; i < ML; i++) begin
      drive_pair(8'd1, 8'd1, 1'b0, lat, sok, hok, tmo);
    end
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd4 || out_count !== 3'(ML)) begin
      fails++;
      $display("FAIL maxlen_close: ov=%b sum=%0d cnt=%0d want 1 4 %0d", out_valid, out_sum, out_count, ML);
    end
    step();
    drive_pair(8'd1, 8'd1, 1'b1, lat, sok, hok, tmo);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd1 || out_count !== 3'd1) begin
      fails++;
      $display("FAIL maxlen_next: ov=%b sum=%0d cnt=%0d want 1 1 1", out_valid, out_sum, out_count);
    end
    step();
  endtask

  task automatic test_backpressure();
    int lat;
    bit sok, hok, tmo;
    bit bad = 1'b0;
    out_ready = 1'b0;
    drive_pair(8'd3, 8'd4, 1'b1, lat, sok, hok, tmo);
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_sum !== 16'd12 || out_count !== 3'd1 ||
          in_ready !== 1'b0 || mac_start !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    tests++;
    if (bad) begin
      fails++;
      $display("FAIL bp_hold: ov=%b sum=%0d cnt=%0d rdy=%b st=%b want 1 12 1 0 0",
               out_valid, out_sum, out_count, in_ready, mac_start);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_retire: ov=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit sok, hok, tmo;
    drive_pair(8'd5, 8'd6, 1'b0, lat, sok, hok, tmo);
    in_valid = 1'b1;
    in_a     = 8'hFF;
    in_b     = 8'd2;
    in_last  = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    step();
    tests++;
    if ({in_ready, busy, out_valid, mac_start} !== 4'b1000 ||
        mac_a !== 0 || mac_b !== 0 || out_sum !== 0 || out_count !== 0) begin
      fails++;
      $display("FAIL reset_mid: rdy=%b busy=%b ov=%b st=%b a=%h sum=%0d cnt=%0d want 1 0 0 0 0 0 0",
               in_ready, busy, out_valid, mac_start, mac_a, out_sum, out_count);
    end
    reset = 1'b0;
    step();
    drive_pair(8'd3, 8'd4, 1'b1, lat, sok, hok, tmo);
    tests++;
    if (out_valid !== 1'b1 || out_sum !== 16'd12 || out_count !== 3'd1) begin
      fails++;
      $display("FAIL reset_after: ov=%b sum=%0d cnt=%0d want 1 12 1", out_valid, out_sum, out_count);
    end
    step();
  endtask

  task automatic test_random();
    int lat;
    bit sok, hok, tmo;
    int ref_sum = 0;
    int ref_cnt = 0;
    int bad = 0;
    logic [7:0] a, b;
    logic lst;
    bit closes;
    for (int i = 0; i < 60; i++) begin
      a   = 8'($urandom);
      b   = 8'($urandom);
      lst = ($urandom_range(0, 3) == 0);
      ref_sum = (ref_sum + int'(a) * int'(b)) % 65536;
      ref_cnt++;
      closes = lst || (ref_cnt == ML);
      drive_pair(a, b, lst, lat, sok, hok, tmo);
      tests++;
      if (lat != 4 + $countones(a) || !sok || !hok || tmo ||
          out_valid !== closes || in_ready === closes) begin
        fails++;
        bad++;
        if (bad < 5)
          $display("FAIL rand_timing[%0d]: a=%h lat=%0d start=%b hold=%b ov=%b want lat=%0d ov=%b",
                   i, a, lat, sok, hok, out_valid, 4 + $countones(a), closes);
      end
      if (closes) begin
        tests++;
        if (out_sum !== 16'(ref_sum) || out_count !== 3'(ref_cnt)) begin
          fails++;
          bad++;
          if (bad < 5)
            $display("FAIL rand_result[%0d]: sum=%0d cnt=%0d want %0d %0d",
                     i, out_sum, out_count, ref_sum, ref_cnt);
        end
        ref_sum = 0;
        ref_cnt = 0;
        if (out_valid) step();
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_single();
    test_vector();
    test_back_to_back();
    test_maxlen();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
